// File: rtl/clock_pkg.sv
// Shared definitions for the century-clock set-mode controller.
//  state_t       : controller state, RUN or one of the five set fields
//  FLD_*         : field index constants, also the set_sel / inc_field bit encoding
//  DAYS_30_MASK  : bit (month-1) set for the 30-day months Apr, Jun, Sep, Nov
//  next_set_state: state reached on a btn_mode press
//  field_sel     : set_sel value for a given state
package clock_pkg;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    SET_YEAR = 3'd1,
    SET_MON  = 3'd2,
    SET_DAY  = 3'd3,
    SET_HOUR = 3'd4,
    SET_MIN  = 3'd5
  } state_t;

  localparam int FLD_SEC  = 0;
  localparam int FLD_MIN  = 1;
  localparam int FLD_HOUR = 2;
  localparam int FLD_DAY  = 3;
  localparam int FLD_MON  = 4;
  localparam int FLD_YEAR = 5;

  localparam logic [11:0] DAYS_30_MASK = 12'h528;

  function automatic state_t next_set_state(input state_t s);
    case (s)
      RUN:      return SET_YEAR;
      SET_YEAR: return SET_MON;
      SET_MON:  return SET_DAY;
      SET_DAY:  return SET_HOUR;
      SET_HOUR: return SET_MIN;
      default:  return RUN;
    endcase
  endfunction

  function automatic logic [2:0] field_sel(input state_t s);
    case (s)
      SET_YEAR: return 3'(FLD_YEAR);
      SET_MON:  return 3'(FLD_MON);
      SET_DAY:  return 3'(FLD_DAY);
      SET_HOUR: return 3'(FLD_HOUR);
      SET_MIN:  return 3'(FLD_MIN);
      default:  return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/days_in_month.sv
// Combinational day-count limit for the day counter.
//  mon  in  6  month 1..12 (anything else treated as a 31-day month)
//  year in  7  year in century 0..99; every multiple of 4 is leap, 00 included
//  days out 5  28, 29, 30 or 31
module days_in_month
  import clock_pkg::*;
(
  input  logic [5:0] mon,
  input  logic [6:0] year,
  output logic [4:0] days
);

  logic [3:0] mon_idx;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    days    = 5'd31;
    mon_idx = mon[3:0] - 4'd1;
    if (mon == 6'd2) begin
      days = ((year % 7'd4) == 7'd0) ? 5'd29 : 5'd28;
    end else if (mon >= 6'd1 && mon <= 6'd12 && DAYS_30_MASK[mon_idx]) begin
      days = 5'd30;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time/date set-mode controller for the century clock.
//  clk, rst_n     clock, asynchronous active-low reset
//  tick_1hz       1 Hz single-cycle enable
//  btn_mode       advance to the next set field (RUN->YEAR->MON->DAY->HOUR->MIN->RUN)
//  btn_inc        increment the selected field
//  cur_mon/year   current month and year, used for the day rollover limit
//  run_en         seconds counter may advance
//  carry_en       inter-field carries may propagate
//  sec_clr        one-cycle seconds clear on leaving SET_MIN by button
//  inc_field      one-hot one-cycle field increment {year,mon,day,hour,min,sec}
//  set_sel        selected field index, 0 in RUN
//  blink          display blank strobe for the selected field
//  rst_numb_mon   month rollover value (MON_MAX)
//  rst_numb_day   day rollover value for cur_mon/cur_year, one cycle latency
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int TIMEOUT_S = 30,
  parameter int MON_MAX   = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [5:0] cur_mon,
  input  logic [6:0] cur_year,
  output logic       run_en,
  output logic       carry_en,
  output logic       sec_clr,
  output logic [5:0] inc_field,
  output logic [2:0] set_sel,
  output logic       blink,
  output logic [5:0] rst_numb_mon,
  output logic [4:0] rst_numb_day
);

  localparam logic [5:0] TIMEOUT_V = 6'(TIMEOUT_S);

  state_t     state;
  state_t     mode_next;
  logic [5:0] idle_cnt;
  logic [4:0] days_limit;

  assign mode_next    = next_set_state(state);
  assign rst_numb_mon = 6'(MON_MAX);

  days_in_month u_days (
    .mon  (cur_mon),
    .year (cur_year),
    .days (days_limit)
  );

  // NOTE: reset is asynchronous so every output returns to its idle value the moment
  // rst_n falls, which also kills any inc_field pulse already launched.
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      run_en    <= 1'b1;
      carry_en  <= 1'b1;
      sec_clr   <= 1'b0;
      inc_field <= 6'd0;
      set_sel   <= 3'd0;
      blink     <= 1'b0;
      idle_cnt  <= 6'd0;
    end else begin
      sec_clr   <= 1'b0;
      inc_field <= 6'd0;
      if (btn_mode) begin
        // Mode press wins over a simultaneous btn_inc; leaving SET_MIN this way
        // restarts the minute from :00.
        state    <= mode_next;
        set_sel  <= field_sel(mode_next);
        run_en   <= (mode_next == RUN);
        carry_en <= (mode_next == RUN);
        sec_clr  <= (mode_next == RUN);
        blink    <= 1'b0;
        idle_cnt <= 6'd0;
      end else if (state != RUN) begin
        if (btn_inc) begin
          // Blank strobe dropped so the user sees the value just stepped.
          inc_field <= 6'd1 << set_sel;
          blink     <= 1'b0;
          idle_cnt  <= 6'd0;
        end else if (idle_cnt == TIMEOUT_V) begin
          // Abandoned set mode: resume running with the values entered, no clear.
          state    <= RUN;
          set_sel  <= 3'd0;
          run_en   <= 1'b1;
          carry_en <= 1'b1;
          blink    <= 1'b0;
          idle_cnt <= 6'd0;
        end else if (tick_1hz) begin
          idle_cnt <= idle_cnt + 6'd1;
          blink    <= ~blink;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_numb_day <= 5'd31;
    end else begin
      rst_numb_day <= days_limit;
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
module tb_clock_set_ctrl;

  localparam int TIMEOUT = 30;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_inc;
  logic [5:0] cur_mon;
  logic [6:0] cur_year;
  logic       run_en;
  logic       carry_en;
  logic       sec_clr;
  logic [5:0] inc_field;
  logic [2:0] set_sel;
  logic       blink;
  logic [5:0] rst_numb_mon;
  logic [4:0] rst_numb_day;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: position in the mode sequence (0 = RUN, 1..5 = year..min),
  // idle seconds, blink level, and the one-cycle outputs.
  int       m_pos;
  int       m_idle;
  bit       m_blink;
  bit       m_sec_clr;
  bit [5:0] m_inc;
  int       m_days;

  clock_set_ctrl #(.TIMEOUT_S(TIMEOUT), .MON_MAX(12)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_1hz     (tick_1hz),
    .btn_mode     (btn_mode),
    .btn_inc      (btn_inc),
    .cur_mon      (cur_mon),
    .cur_year     (cur_year),
    .run_en       (run_en),
    .carry_en     (carry_en),
    .sec_clr      (sec_clr),
    .inc_field    (inc_field),
    .set_sel      (set_sel),
    .blink        (blink),
    .rst_numb_mon (rst_numb_mon),
    .rst_numb_day (rst_numb_day)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int sel_of(input int pos);
    return (pos == 0) ? 0 : 6 - pos;
  endfunction

  function automatic int ref_days(input int mon, input int yr);
    if (mon == 2) return (yr % 4 == 0) ? 29 : 28;
    if (mon == 4 || mon == 6 || mon == 9 || mon == 11) return 30;
    return 31;
  endfunction

  task automatic model_reset();
    m_pos = 0; m_idle = 0; m_blink = 0; m_sec_clr = 0; m_inc = 0; m_days = 31;
  endtask

  task automatic model_step(input bit m, input bit i, input bit t, input int mon, input int yr);
    m_sec_clr = 0;
    m_inc     = 0;
    m_days    = ref_days(mon, yr);
    if (m) begin
      m_pos     = (m_pos + 1) % 6;
      m_sec_clr = (m_pos == 0);
      m_idle    = 0;
      m_blink   = 0;
    end else if (m_pos != 0) begin
      if (i) begin
        m_inc   = 6'(1 << sel_of(m_pos));
        m_idle  = 0;
        m_blink = 0;
      end else if (m_idle == TIMEOUT) begin
        m_pos = 0; m_idle = 0; m_blink = 0;
      end else if (t) begin
        m_idle++;
        m_blink = ~m_blink;
      end
    end
  endtask

  // One clock: inputs held across the rising edge, outputs then observed at the falling edge.
  task automatic cycle(input bit m, input bit i, input bit t);
    btn_mode = m; btn_inc = i; tick_1hz = t;
    @(posedge clk);
    model_step(m, i, t, int'(cur_mon), int'(cur_year));
    @(negedge clk);
    btn_mode = 0; btn_inc = 0; tick_1hz = 0;
  endtask

  task automatic test_reset();
    n_tests++;
    if ({run_en, carry_en, sec_clr, inc_field, set_sel, blink} !== {1'b1, 1'b1, 1'b0, 6'd0, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state got run=%0b carry=%0b clr=%0b inc=%b sel=%0d blink=%0b want 1 1 0 000000 0 0",
               run_en, carry_en, sec_clr, inc_field, set_sel, blink);
    end
    n_tests++;
    if (rst_numb_day !== 5'd31 || rst_numb_mon !== 6'd12) begin
      n_fail++;
      $display("FAIL reset_limits got day=%0d mon=%0d want 31 12", rst_numb_day, rst_numb_mon);
    end
    repeat (3) cycle(1, 0, 0);
    n_tests++;
    if (set_sel !== 3'd3) begin
      n_fail++;
      $display("FAIL reset_enter_day got sel=%0d want 3", set_sel);
    end
    // btn_inc is registered, then reset lands before the pulse is observed for a full cycle.
    btn_inc = 1;
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    model_reset();
    n_tests++;
    if ({run_en, carry_en, inc_field, set_sel, blink} !== {1'b1, 1'b1, 6'd0, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_day got run=%0b carry=%0b inc=%b sel=%0d blink=%0b want 1 1 000000 0 0",
               run_en, carry_en, inc_field, set_sel, blink);
    end
    @(negedge clk);
    btn_inc = 0;
    rst_n   = 1;
    cycle(0, 0, 0);
    n_tests++;
    if (inc_field !== 6'd0 || set_sel !== 3'd0 || run_en !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_after got inc=%b sel=%0d run=%0b want 000000 0 1", inc_field, set_sel, run_en);
    end
  endtask

  task automatic test_mode_cycle();
    int exp_sel[6] = '{5, 4, 3, 2, 1, 0};
    int clr_seen = 0;
    for (int k = 0; k < 6; k++) begin
      cycle(1, 0, 0);
      if (sec_clr === 1'b1) clr_seen++;
      n_tests++;
      if (set_sel !== 3'(exp_sel[k]) || run_en !== (k == 5) || carry_en !== (k == 5) || sec_clr !== (k == 5)) begin
        n_fail++;
        $display("FAIL mode_step%0d got sel=%0d run=%0b carry=%0b clr=%0b want sel=%0d run/carry/clr=%0b",
                 k, set_sel, run_en, carry_en, sec_clr, exp_sel[k], (k == 5));
      end
    end
    cycle(0, 0, 0);
    if (sec_clr === 1'b1) clr_seen++;
    n_tests++;
    if (clr_seen != 1) begin
      n_fail++;
      $display("FAIL mode_sec_clr_pulses got %0d want 1", clr_seen);
    end
  endtask

  task automatic test_inc();
    int pulses = 0;
    repeat (2) cycle(1, 0, 0);
    for (int r = 0; r < 3; r++) begin
      cycle(0, 0, 0);
      n_tests++;
      if (inc_field !== 6'd0 || run_en !== 1'b0 || carry_en !== 1'b0) begin
        n_fail++;
        $display("FAIL inc_idle%0d got inc=%b run=%0b carry=%0b want 000000 0 0", r, inc_field, run_en, carry_en);
      end
      cycle(0, 1, 0);
      if (inc_field === 6'b010000) pulses++;
      n_tests++;
      if (inc_field !== 6'b010000 || run_en !== 1'b0 || carry_en !== 1'b0) begin
        n_fail++;
        $display("FAIL inc_pulse%0d got inc=%b run=%0b carry=%0b want 010000 0 0", r, inc_field, run_en, carry_en);
      end
    end
    cycle(0, 0, 0);
    n_tests++;
    if (pulses != 3 || inc_field !== 6'd0) begin
      n_fail++;
      $display("FAIL inc_count got pulses=%0d inc=%b want 3 000000", pulses, inc_field);
    end
    repeat (4) cycle(1, 0, 0);
  endtask

  task automatic test_mode_inc_same();
    cycle(1, 0, 0);
    cycle(1, 1, 0);
    n_tests++;
    if (set_sel !== 3'd4 || inc_field !== 6'd0) begin
      n_fail++;
      $display("FAIL same_cycle got sel=%0d inc=%b want 4 000000", set_sel, inc_field);
    end
    cycle(0, 0, 0);
    n_tests++;
    if (inc_field !== 6'd0) begin
      n_fail++;
      $display("FAIL same_cycle_late got inc=%b want 000000", inc_field);
    end
    repeat (4) cycle(1, 0, 0);
  endtask

  task automatic test_timeout();
    repeat (4) cycle(1, 0, 0);
    cycle(0, 0, 1);
    n_tests++;
    if (blink !== 1'b1) begin
      n_fail++;
      $display("FAIL blink_toggle got %0b want 1", blink);
    end
    repeat (27) cycle(0, 0, 1);
    cycle(0, 1, 1);
    n_tests++;
    if (inc_field !== 6'b000100 || blink !== 1'b0 || set_sel !== 3'd2) begin
      n_fail++;
      $display("FAIL timeout_inc got inc=%b blink=%0b sel=%0d want 000100 0 2", inc_field, blink, set_sel);
    end
    repeat (29) cycle(0, 0, 1);
    n_tests++;
    if (set_sel !== 3'd2) begin
      n_fail++;
      $display("FAIL timeout_early got sel=%0d want 2", set_sel);
    end
    cycle(0, 0, 1);
    n_tests++;
    if (set_sel !== 3'd2) begin
      n_fail++;
      $display("FAIL timeout_at30 got sel=%0d want 2", set_sel);
    end
    cycle(0, 0, 0);
    n_tests++;
    if (set_sel !== 3'd0 || sec_clr !== 1'b0 || run_en !== 1'b1 || carry_en !== 1'b1 || blink !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_exit got sel=%0d clr=%0b run=%0b carry=%0b blink=%0b want 0 0 1 1 0",
               set_sel, sec_clr, run_en, carry_en, blink);
    end
  endtask

  task automatic test_days();
    int mons[9]  = '{2, 2, 2, 2, 4, 12, 0, 13, 9};
    int years[9] = '{0, 1, 24, 99, 5, 5, 5, 5, 3};
    int exps[9]  = '{29, 28, 29, 28, 30, 31, 31, 31, 30};
    for (int k = 0; k < 9; k++) begin
      cur_mon  = 6'(mons[k]);
      cur_year = 7'(years[k]);
      cycle(0, 0, 0);
      n_tests++;
      if (rst_numb_day !== 5'(exps[k])) begin
        n_fail++;
        $display("FAIL days_mon%0d_yr%0d got %0d want %0d", mons[k], years[k], rst_numb_day, exps[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [17:0] got;
    logic [17:0] want;
    bit m, i, t;
    for (int n = 0; n < 1200; n++) begin
      if (n < 400) begin
        m = ($urandom_range(0, 7) == 0);
        i = ($urandom_range(0, 3) == 0);
      end else begin
        m = ($urandom_range(0, 199) == 0);
        i = ($urandom_range(0, 149) == 0);
      end
      t        = ($urandom_range(0, 1) == 0);
      cur_mon  = 6'($urandom_range(0, 15));
      cur_year = 7'($urandom_range(0, 99));
      cycle(m, i, t);
      got  = {run_en, carry_en, sec_clr, inc_field, set_sel, blink, rst_numb_day};
      want = {m_pos == 0, m_pos == 0, m_sec_clr, m_inc, 3'(sel_of(m_pos)), m_blink, 5'(m_days)};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL random_cycle%0d got %b want %b (run,carry,clr,inc,sel,blink,day)", n, got, want);
      end
    end
  endtask

  initial begin
    rst_n    = 0;
    tick_1hz = 0;
    btn_mode = 0;
    btn_inc  = 0;
    cur_mon  = 6'd1;
    cur_year = 7'd0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    test_reset();
    test_mode_cycle();
    test_inc();
    test_mode_inc_same();
    test_timeout();
    test_days();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
